// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply sequencer: op codes, FSM states,
// counter width and the NOP classification used by both accept and stall.
package hilo_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_MFHI  = 3'd3,
        OP_MFLO  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int CNT_W = 4;

    // The reserved code behaves exactly like NOP: never accepted, never stalls.
    function automatic logic is_nop(input logic [2:0] op);
        return (op == OP_NOP) || (op == OP_RSVD);
    endfunction

endpackage

// File: rtl/hilo_unit.sv
// Multiply sequencing and HI/LO registers: launches operands to an external
// combinational multiplier, waits MUL_CYCLES, then captures the product.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | accepts MULT/MULTU/MFHI/MFLO/MTHI/MTLO, no stall
// BUSY    | operands held on mul_*, cnt counts down, capture at cnt==0
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        mul_sign,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_z,
    output logic        stall,
    output logic        busy,
    output logic [31:0] rd_val,
    output logic        rd_valid,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       rd_val_q, rd_val_d;
    logic              rd_valid_q, rd_valid_d;
    logic [31:0]       mul_a_q, mul_a_d;
    logic [31:0]       mul_b_q, mul_b_d;
    logic              mul_sign_q, mul_sign_d;
    logic              accept;

    // Stall covers the completing cycle too, so a waiting MFHI/MFLO sees the new product.
    assign stall  = (state_q == ST_BUSY) && op_valid && !is_nop(op);
    assign accept = op_valid && !stall && !is_nop(op);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        rd_val_d   = rd_val_q;
        rd_valid_d = 1'b0;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        mul_sign_d = mul_sign_q;

        if (state_q == ST_BUSY) begin
            if (cnt_q == '0) begin
                hi_d    = mul_z[63:32];
                lo_d    = mul_z[31:0];
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (accept) begin
            case (op)
                OP_MULT, OP_MULTU: begin
                    mul_a_d    = rs_val;
                    mul_b_d    = rt_val;
                    mul_sign_d = (op == OP_MULT);
                    cnt_d      = CNT_INIT;
                    state_d    = ST_BUSY;
                end
                OP_MFHI: begin
                    rd_val_d   = hi_q;
                    rd_valid_d = 1'b1;
                end
                OP_MFLO: begin
                    rd_val_d   = lo_q;
                    rd_valid_d = 1'b1;
                end
                OP_MTHI: hi_d = rs_val;
                OP_MTLO: lo_d = rs_val;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            rd_val_q   <= '0;
            rd_valid_q <= 1'b0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            mul_sign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            rd_val_q   <= rd_val_d;
            rd_valid_q <= rd_valid_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            mul_sign_q <= mul_sign_d;
        end
    end

    assign busy     = (state_q == ST_BUSY);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign rd_val   = rd_val_q;
    assign rd_valid = rd_valid_q;
    assign mul_a    = mul_a_q;
    assign mul_b    = mul_b_q;
    assign mul_sign = mul_sign_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: two instances (MUL_CYCLES=4 and 1), each with a
// behavioural multiplier; MFHI/MFLO results are checked through a scoreboard.
module tb_hilo_unit;

    localparam logic [2:0] NOP = 3'd0, MULT = 3'd1, MULTU = 3'd2, MFHI = 3'd3,
                           MFLO = 3'd4, MTHI = 3'd5, MTLO = 3'd6, RSVD = 3'd7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // instance with MUL_CYCLES=4
    logic        op_valid = 1'b0;
    logic [2:0]  op = NOP;
    logic [31:0] rs_val = '0, rt_val = '0;
    logic        mul_sign, stall, busy, rd_valid;
    logic [31:0] mul_a, mul_b, rd_val, hi, lo;
    logic [63:0] mul_z;

    // instance with MUL_CYCLES=1
    logic        op_valid1 = 1'b0;
    logic [2:0]  op1 = NOP;
    logic [31:0] rs_val1 = '0, rt_val1 = '0;
    logic        mul_sign1, stall1, busy1, rd_valid1;
    logic [31:0] mul_a1, mul_b1, rd_val1, hi1, lo1;
    logic [63:0] mul_z1;

    function automatic logic [63:0] mult(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    assign mul_z  = mult(mul_sign, mul_a, mul_b);
    assign mul_z1 = mult(mul_sign1, mul_a1, mul_b1);

    hilo_unit #(.MUL_CYCLES(4)) u4 (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .rs_val(rs_val), .rt_val(rt_val),
        .mul_sign(mul_sign), .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z), .stall(stall),
        .busy(busy), .rd_val(rd_val), .rd_valid(rd_valid), .hi(hi), .lo(lo));

    hilo_unit #(.MUL_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .op_valid(op_valid1), .op(op1), .rs_val(rs_val1), .rt_val(rt_val1),
        .mul_sign(mul_sign1), .mul_a(mul_a1), .mul_b(mul_b1), .mul_z(mul_z1), .stall(stall1),
        .busy(busy1), .rd_val(rd_val1), .rd_valid(rd_valid1), .hi(hi1), .lo(lo1));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every rd_valid pulse must match the oldest expectation.
    always begin
        @(posedge clk);
        #1;
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got rd_val 0x%0h with nothing expected", rd_val);
            end else begin
                chk("rd_val", {32'b0, rd_val}, {32'b0, exp_q.pop_front()});
            end
        end
        if (rd_valid1 === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL rd_valid1: got 1 expected 0");
        end
    end

    // Counts cycles with busy (or stall) high; bounded so a stuck DUT still ends.
    task automatic count_busy(input bit use_stall, output int n);
        n = 0;
        while ((use_stall ? stall : busy) && n < 20) begin
            n++;
            step();
        end
    endtask

    int n;

    initial begin
        step();
        step();
        rst = 1'b0;
        chk("reset_hilo", {hi, lo}, 64'h0);
        chk("reset_mul", {mul_a, mul_b}, 64'h0);
        chk("reset_flags", {60'b0, mul_sign, rd_valid, busy, stall}, 64'h0);
        chk("reset_rdval", {32'b0, rd_val}, 64'h0);

        // MULT signed: -2 * 3
        op_valid = 1'b1; op = MULT; rs_val = 32'hFFFF_FFFE; rt_val = 32'd3;
        chk("idle_no_stall", {63'b0, stall}, 64'h0);
        step();
        op_valid = 1'b0;
        chk("mult_operands", {mul_a, mul_b}, {32'hFFFF_FFFE, 32'd3});
        chk("mult_sign", {63'b0, mul_sign}, 64'h1);
        count_busy(1'b0, n);
        chk("mult_busy_cycles", 64'(n), 64'd4);
        chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

        // MULTU with same operands
        op_valid = 1'b1; op = MULTU;
        step();
        op_valid = 1'b0;
        chk("multu_sign", {63'b0, mul_sign}, 64'h0);
        count_busy(1'b0, n);
        chk("multu_busy_cycles", 64'(n), 64'd4);
        chk("multu_hilo", {hi, lo}, 64'h0000_0002_FFFF_FFFA);

        // MFLO presented right behind a MULT: stalls 4 cycles with HI/LO frozen
        op_valid = 1'b1; op = MULT; rs_val = 32'd7; rt_val = 32'd6;
        step();
        op = MFLO;
        n = 0;
        while (stall && n < 20) begin
            chk("stall_hilo_frozen", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
            n++;
            step();
        end
        chk("mflo_stall_cycles", 64'(n), 64'd4);
        chk("mflo_new_hilo", {hi, lo}, 64'd42);
        exp_q.push_back(32'd42);
        step();
        op_valid = 1'b0;
        step();
        chk("rd_valid_drops", {63'b0, rd_valid}, 64'h0);

        // MTHI then MFHI on consecutive edges
        op_valid = 1'b1; op = MTHI; rs_val = 32'h1234_5678;
        step();
        chk("mthi_hi", {32'b0, hi}, 64'h1234_5678);
        op = MFHI;
        exp_q.push_back(32'h1234_5678);
        step();
        op_valid = 1'b0;
        chk("mthi_lo_unchanged", {32'b0, lo}, 64'd42);

        // MTLO then MFLO
        op_valid = 1'b1; op = MTLO; rs_val = 32'hAABB_CCDD;
        step();
        chk("mtlo_lo", {32'b0, lo}, 64'hAABB_CCDD);
        op = MFLO;
        exp_q.push_back(32'hAABB_CCDD);
        step();

        // Reserved op behaves as NOP
        op = RSVD; rs_val = 32'hDEAD_BEEF;
        step();
        chk("rsvd_no_effect", {hi, lo}, {32'h1234_5678, 32'hAABB_CCDD});
        chk("rsvd_no_busy", {63'b0, busy}, 64'h0);
        op_valid = 1'b0;

        // Reset during the second BUSY cycle
        op_valid = 1'b1; op = MULTU; rs_val = 32'd5; rt_val = 32'd5;
        step();
        op_valid = 1'b0;
        step();
        chk("pre_reset_busy", {63'b0, busy}, 64'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midbusy_reset_hilo", {hi, lo}, 64'h0);
        chk("midbusy_reset_mul", {mul_a, mul_b}, 64'h0);
        chk("midbusy_reset_flags", {60'b0, mul_sign, rd_valid, busy, stall}, 64'h0);
        chk("midbusy_reset_rdval", {32'b0, rd_val}, 64'h0);
        step(); step(); step();
        chk("no_capture_after_reset", {hi, lo}, 64'h0);

        op_valid = 1'b1; op = MULTU; rs_val = 32'd3; rt_val = 32'd4;
        step();
        op_valid = 1'b0;
        count_busy(1'b0, n);
        chk("post_reset_busy_cycles", 64'(n), 64'd4);
        chk("post_reset_hilo", {hi, lo}, 64'd12);

        // MUL_CYCLES=1 back-to-back MULTs
        op_valid1 = 1'b1; op1 = MULT; rs_val1 = 32'd2; rt_val1 = 32'd3;
        step();
        chk("b2b_first_busy", {63'b0, busy1}, 64'h1);
        rs_val1 = 32'd5; rt_val1 = 32'd7;
        n = 0;
        while (stall1 && n < 20) begin
            n++;
            step();
        end
        chk("b2b_stall_cycles", 64'(n), 64'd1);
        chk("b2b_intermediate", {hi1, lo1}, 64'd6);
        step();
        op_valid1 = 1'b0;
        chk("b2b_second_busy", {63'b0, busy1}, 64'h1);
        step();
        chk("b2b_final", {hi1, lo1}, 64'd35);
        chk("b2b_idle", {63'b0, busy1}, 64'h0);

        step(); step();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Multiply sequencing and HI/LO register stage of the MIPS pipeline. Accepts MULT/MULTU/MFHI/MFLO/MTHI/MTLO from EX, drives registered operands into the combinational 32x32 multiplier, and holds them stable for a fixed multicycle window. It then captures the 64-bit product into HI/LO. It stalls the pipeline while a multiply is in flight.

## Interface
- MUL_CYCLES, 4: cycles allowed for the multiplier's combinational path; legal range 1..15.

- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  EX presents an operation this cycle.
- op  in  3  operation code (hilo_pkg).
- rs_val  in  32  rs operand (multiplicand, MTHI/MTLO source).
- rt_val  in  32  rt operand (multiplier).
- mul_sign  out  1  to multiplier: 1 = signed (MULT).
- mul_a  out  32  to multiplier A.
- mul_b  out  32  to multiplier B.
- mul_z  in  64  product from multiplier.
- stall  out  1  hold EX; current op is not accepted.
- busy  out  1  multiply in flight.
- rd_val  out  32  MFHI/MFLO result.
- rd_valid  out  1  rd_val updated at the last edge.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- States: IDLE, BUSY. A 4-bit down-counter cnt is used only in BUSY.
- Accept: an op is accepted on an edge where op_valid=1, stall=0, and op is not NOP. Reserved op code 7 is treated as NOP.
- IDLE + MULT/MULTU accepted:
  - mul_a<=rs_val, mul_b<=rt_val, mul_sign<=(op==MULT), cnt<=MUL_CYCLES-1.
  - Next state BUSY.
- BUSY:
  - If cnt!=0: cnt decrements each edge.
  - If cnt==0: {hi,lo}<=mul_z, next state IDLE.
  - mul_a, mul_b and mul_sign are held constant throughout BUSY.
- MTHI accepted: hi<=rs_val. MTLO accepted: lo<=rs_val. State does not change.
- MFHI/MFLO accepted: rd_val<=hi or lo (the value before this edge), rd_valid<=1. rd_valid is 0 on every other edge.
- stall is combinational: stall = (state==BUSY) & op_valid & (op not NOP). It is asserted in every BUSY cycle, including the completing cycle (cnt==0). Upstream holds op/rs_val/rt_val while stall=1. A stalled op is accepted on the first IDLE cycle and sees the new HI/LO.
- busy = (state==BUSY).
- Reset, including mid-BUSY:
  - state=IDLE, cnt=0.
  - hi, lo, rd_val, mul_a, mul_b = 0.
  - mul_sign, rd_valid, busy, stall = 0.
  - An in-flight product is discarded.
- Width rules:
  - The product is taken verbatim from mul_z: hi=mul_z[63:32], lo=mul_z[31:0].
  - No sign handling here; sign handling belongs to the multiplier, controlled by mul_sign.

## Timing
- MULT accepted at edge E0:
  - busy=1 for exactly MUL_CYCLES cycles after E0.
  - HI/LO are written at edge E0+MUL_CYCLES.
  - busy=0 after that edge.
- MUL_CYCLES=1: a single BUSY cycle; the product is captured at the next edge.
- MTHI/MTLO: the new value is visible on hi/lo one cycle after acceptance.
- MFHI/MFLO: rd_val/rd_valid are valid one cycle after acceptance.
- Back-to-back MULT: the second MULT stalls for MUL_CYCLES cycles, then is accepted. Its BUSY starts immediately after.
- IDLE has no structural hazard: MTHI followed by MFHI on consecutive edges returns the new HI value.

## Structure
- hilo_pkg holds:
  - Op codes: NOP=0, MULT=1, MULTU=2, MFHI=3, MFLO=4, MTHI=5, MTLO=6, 7 reserved.
  - State enum {IDLE, BUSY}.
  - Counter width constant (4).
- No sub-module. The multiplier stays a sibling instance wired through mul_*, so it can be swapped for a sequential multiplier without touching this block.

## Test plan
- MULT, rs=0xFFFFFFFE, rt=3, MUL_CYCLES=4, bench instantiates the team multiplier:
  - busy high for 4 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU, same operands: hi=0x00000002, lo=0xFFFFFFFA.
- MFLO presented the cycle after a MULT:
  - stall=1 for 4 cycles; HI/LO unchanged throughout.
  - Then accepted; next cycle rd_valid=1, rd_val=new lo.
- MTHI 0x12345678, then MFHI on the next edge: rd_val=0x12345678, rd_valid=1 one cycle later; lo unchanged.
- rst pulsed during cycle 2 of BUSY:
  - All outputs read 0 the next cycle.
  - mul_z is not captured.
  - A MULT right after reset operates normally.
- MUL_CYCLES=1, back-to-back MULTs (2*3, then 5*7):
  - Second MULT stalls exactly 1 cycle.
  - HI/LO end at 0/35, with an intermediate 0/6.
